// File: rtl/reset_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : reset_sequencer_if
// Description : Request inputs and reset outputs of the board reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface reset_sequencer_if #(
  parameter int N_CHANNELS = 3
);
  logic                  btn_i;
  logic                  soft_reset_i;
  logic                  wdt_kick_i;
  logic [N_CHANNELS-1:0] reset_o;
  logic                  all_released_o;
  logic [1:0]            cause_o;

  modport master (
    output btn_i, soft_reset_i, wdt_kick_i,
    input  reset_o, all_released_o, cause_o
  );

  modport slave (
    input  btn_i, soft_reset_i, wdt_kick_i,
    output reset_o, all_released_o, cause_o
  );
endinterface
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reset_sequencer
// Description : Board reset controller with staggered channel release and cause log.
// Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer #(
  parameter int N_CHANNELS      = 3,
  parameter int POR_CYCLES      = 63,
  parameter int STAGGER_CYCLES  = 16,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1,
  parameter int WDT_CYCLES      = 0
) (
  input wire logic         clk,
  input wire logic         reset_i,
  reset_sequencer_if.slave bus
);

  localparam int HOLD_W    = $clog2(POR_CYCLES + 1);
  localparam int STG_W     = (STAGGER_CYCLES > 0) ? $clog2(STAGGER_CYCLES + 1) : 1;
  localparam int DB_W      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam bit STAGGERED = (STAGGER_CYCLES > 0) && (N_CHANNELS > 1);
  localparam logic BTN_IDLE = BTN_ACTIVE_LOW;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  // Initial values mirror reset values so FPGA configuration acts as a POR.
  logic                  btn_s1_q     = BTN_IDLE;
  logic                  btn_s2_q     = BTN_IDLE;
  logic                  db_pressed_q = 1'b0;
  logic [DB_W-1:0]       db_cnt_q     = '0;
  state_e                state_q      = ST_HOLD;
  state_e                state_d;
  logic [HOLD_W-1:0]     hold_cnt_q   = '0;
  logic [HOLD_W-1:0]     hold_cnt_d;
  logic [STG_W-1:0]      stg_cnt_q    = '0;
  logic [STG_W-1:0]      stg_cnt_d;
  logic [N_CHANNELS-1:0] rst_q        = '1;
  logic [N_CHANNELS-1:0] rst_d;
  logic                  all_rel_q    = 1'b0;
  logic                  all_rel_d;
  logic [1:0]            cause_q      = 2'd0;
  logic [1:0]            cause_d;

  logic btn_raw_pressed;
  logic wdt_expire;
  logic req;

  assign btn_raw_pressed = btn_s2_q ^ BTN_ACTIVE_LOW;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      btn_s1_q     <= BTN_IDLE;
      btn_s2_q     <= BTN_IDLE;
      db_pressed_q <= 1'b0;
      db_cnt_q     <= '0;
    end else begin
      btn_s1_q <= bus.btn_i;
      btn_s2_q <= btn_s1_q;
      if (btn_raw_pressed == db_pressed_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_pressed_q <= btn_raw_pressed;
        db_cnt_q     <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end
  end

  generate
    if (WDT_CYCLES > 0) begin : g_wdt
      localparam int WDT_W = $clog2(WDT_CYCLES + 1);
      logic [WDT_W-1:0] wdt_cnt_q = '0;

      // A kick on the terminal cycle suppresses the expiry.
      assign wdt_expire = (state_q == ST_RUN) && !bus.wdt_kick_i &&
                          (wdt_cnt_q == WDT_W'(WDT_CYCLES - 1));

      always_ff @(posedge clk) begin
        if (reset_i || (state_q != ST_RUN) || bus.wdt_kick_i) begin
          wdt_cnt_q <= '0;
        end else if (wdt_cnt_q != WDT_W'(WDT_CYCLES - 1)) begin
          wdt_cnt_q <= wdt_cnt_q + 1'b1;
        end
      end
    end else begin : g_no_wdt
      assign wdt_expire = 1'b0;
    end
  endgenerate

  assign req = reset_i | db_pressed_q | bus.soft_reset_i | wdt_expire;

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    stg_cnt_d  = stg_cnt_q;
    rst_d      = rst_q;
    all_rel_d  = all_rel_q;
    cause_d    = cause_q;
    if (req) begin
      state_d    = ST_HOLD;
      hold_cnt_d = '0;
      stg_cnt_d  = '0;
      rst_d      = '1;
      all_rel_d  = 1'b0;
      if (reset_i)           cause_d = 2'd0;
      else if (db_pressed_q) cause_d = 2'd1;
      else if (wdt_expire)   cause_d = 2'd3;
      else                   cause_d = 2'd2;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (hold_cnt_q == HOLD_W'(POR_CYCLES - 1)) begin
            hold_cnt_d = '0;
            stg_cnt_d  = '0;
            if (STAGGERED) begin
              state_d = ST_RELEASE;
              rst_d   = rst_q << 1;
            end else begin
              state_d   = ST_RUN;
              rst_d     = '0;
              all_rel_d = 1'b1;
            end
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (stg_cnt_q == STG_W'(STAGGER_CYCLES - 1)) begin
            stg_cnt_d = '0;
            rst_d     = rst_q << 1;
            if (rst_d == '0) begin
              state_d   = ST_RUN;
              all_rel_d = 1'b1;
            end
          end else begin
            stg_cnt_d = stg_cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_HOLD;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q    <= ST_HOLD;
      hold_cnt_q <= '0;
      stg_cnt_q  <= '0;
      rst_q      <= '1;
      all_rel_q  <= 1'b0;
      cause_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      stg_cnt_q  <= stg_cnt_d;
      rst_q      <= rst_d;
      all_rel_q  <= all_rel_d;
      cause_q    <= cause_d;
    end
  end

  assign bus.reset_o        = rst_q;
  assign bus.all_released_o = all_rel_q;
  assign bus.cause_o        = cause_q;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reset_sequencer
// Description : Randomised bench for reset_sequencer against a timing-rule model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

  localparam int N      = 3;
  localparam int POR    = 8;
  localparam int STG    = 4;
  localparam int DB     = 5;
  localparam int WDT    = 20;
  localparam int RUN_AT = POR + (N - 1) * STG;

  logic clk = 1'b0;
  logic reset_i;

  reset_sequencer_if #(.N_CHANNELS(N)) bus ();

  reset_sequencer #(
    .N_CHANNELS     (N),
    .POR_CYCLES     (POR),
    .STAGGER_CYCLES (STG),
    .DEBOUNCE_CYCLES(DB),
    .BTN_ACTIVE_LOW (1'b1),
    .WDT_CYCLES     (WDT)
  ) dut (
    .clk    (clk),
    .reset_i(reset_i),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: outputs derive from the length of the current request-free run.
  int         m_free  = 0;
  int         m_age   = 0;
  bit         m_db    = 1'b0;
  bit         m_sync0 = 1'b0;
  bit         m_sync1 = 1'b0;
  bit         m_win[$];
  logic [1:0] m_cause = 2'd0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] exp_rst();
    logic [N-1:0] ones = '1;
    int k;
    if (m_free < POR) return ones;
    k = (m_free - POR) / STG + 1;
    if (k > N) k = N;
    return ones << k;
  endfunction

  function automatic bit will_expire(input bit k);
    return (m_free >= RUN_AT) && !k && (m_age == WDT - 1);
  endfunction

  task automatic model_step(input bit r, input bit p, input bit s, input bit k);
    bit in_run = (m_free >= RUN_AT);
    bit expire = will_expire(k);
    bit db_old = m_db;
    bit req    = r || db_old || s || expire;
    bit sample = m_sync1;
    bit all_diff;

    if (req) begin
      m_free = 0;
      if (r)           m_cause = 2'd0;
      else if (db_old) m_cause = 2'd1;
      else if (expire) m_cause = 2'd3;
      else             m_cause = 2'd2;
    end else if (m_free < 1000000) begin
      m_free++;
    end

    if (!in_run || k) m_age = 0;
    else              m_age++;

    if (r) begin
      m_db    = 1'b0;
      m_sync0 = 1'b0;
      m_sync1 = 1'b0;
      m_win.delete();
    end else begin
      m_sync1 = m_sync0;
      m_sync0 = p;
      m_win.push_back(sample);
      if (m_win.size() > DB) void'(m_win.pop_front());
      all_diff = (m_win.size() == DB);
      foreach (m_win[i]) if (m_win[i] == m_db) all_diff = 1'b0;
      if (all_diff) begin
        m_db = !m_db;
        m_win.delete();
      end
    end
  endtask

  // Called at a negedge; drives one cycle, steps the model and compares.
  task automatic cycle(input bit r, input bit p, input bit s, input bit k);
    reset_i          = r;
    bus.btn_i        = !p;
    bus.soft_reset_i = s;
    bus.wdt_kick_i   = k;
    @(posedge clk);
    model_step(r, p, s, k);
    #1;
    check_eq("reset_o", {29'd0, bus.reset_o}, {29'd0, exp_rst()});
    check_eq("all_released", {31'd0, bus.all_released_o}, {31'd0, m_free >= RUN_AT});
    check_eq("cause", {30'd0, bus.cause_o}, {30'd0, m_cause});
    @(negedge clk);
  endtask

  initial begin
    bit found;
    int press_left;
    bit pressed;

    reset_i          = 1'b1;
    bus.btn_i        = 1'b1;
    bus.soft_reset_i = 1'b0;
    bus.wdt_kick_i   = 1'b0;
    @(negedge clk);

    // Power-up hold, full staggered release, then watchdog expiry with no kicks.
    repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (50) cycle(1'b0, 1'b0, 1'b0, 1'b0);

    // Regular kicks keep the watchdog quiet.
    for (int i = 0; i < 1040; i++) cycle(1'b0, 1'b0, 1'b0, (i % 10) == 0);
    check_eq("kick_run_held", {31'd0, bus.all_released_o}, 32'd1);

    // Button glitch, then a long press.
    repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (8) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("glitch_ignored", {31'd0, bus.all_released_o}, 32'd1);
    repeat (20) cycle(1'b0, 1'b1, 1'b0, 1'b1);
    repeat (12) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("button_cause", {30'd0, bus.cause_o}, 32'd1);

    // Soft reset while only channel 0 is released.
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (exp_rst() == 3'b110) found = 1'b1;
      else cycle(1'b0, 1'b0, 1'b0, 1'b0);
    end
    check_eq("wait_release", {31'd0, found}, 32'd1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("soft_mid_release", {29'd0, bus.reset_o}, 32'h7);
    check_eq("soft_cause", {30'd0, bus.cause_o}, 32'd2);

    // Soft pulse on the watchdog expiry cycle: watchdog wins.
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      if (will_expire(1'b0)) found = 1'b1;
      else cycle(1'b0, 1'b0, 1'b0, 1'b0);
    end
    check_eq("wait_expiry", {31'd0, found}, 32'd1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("soft_wdt_cause", {30'd0, bus.cause_o}, 32'd3);

    // reset_i together with a debounced button request: POR wins.
    repeat (20) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_db) found = 1'b1;
      else cycle(1'b0, 1'b1, 1'b0, 1'b1);
    end
    check_eq("wait_debounce", {31'd0, found}, 32'd1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    check_eq("por_btn_cause", {30'd0, bus.cause_o}, 32'd0);

    // Random traffic on every source.
    press_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (press_left > 0) begin
        press_left--;
      end else if ($urandom_range(39) == 0) begin
        press_left = ($urandom_range(1) == 0) ? int'($urandom_range(4, 1))
                                              : int'($urandom_range(30, 8));
      end
      pressed = (press_left > 0);
      cycle($urandom_range(499) == 0, pressed, $urandom_range(199) == 0,
            $urandom_range(11) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
